// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / MEM-WB stage.
//   DATA_W  : datapath width
//   REG_W   : GPR index width
//   state_t : memory-port controller state
package mem_wb_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;
endpackage

// File: rtl/mem_port_ctrl.sv
// Data-memory port controller: runs one req/ack access at a time and
// abandons it after MAX_WAIT cycles without an acknowledge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : memory instruction present (only looked at in IDLE)
//   addr, wdata, we : access parameters, latched when the access starts
//   mem_ack         : memory acknowledge
//   state           : current controller state
//   req, mem_we, mem_addr, mem_wdata : registered memory request
//   ack_hit         : access completes this cycle
//   timeout         : access is abandoned this cycle (never with mem_ack)
module mem_port_ctrl
    import mem_wb_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              mem_ack,
    output state_t            state,
    output logic              req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ack_hit,
    output logic              timeout
);
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t            state_reg;
    logic              req_reg;
    logic              we_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [7:0]        wait_cnt_reg;

    // In ACCESS req is always high, so an ack there is a real completion;
    // an ack seen in IDLE is ignored. Ack beats a simultaneous timeout.
    assign ack_hit = (state_reg == ACCESS) && mem_ack;
    assign timeout = (state_reg == ACCESS) && !mem_ack && (wait_cnt_reg == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ACCESS;
                        req_reg      <= 1'b1;
                        we_reg       <= we;
                        addr_reg     <= addr;
                        wdata_reg    <= wdata;
                        wait_cnt_reg <= '0;
                    end
                end
                ACCESS: begin
                    if (ack_hit || timeout) begin
                        state_reg <= IDLE;
                        req_reg   <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign state     = state_reg;
    assign req       = req_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
endmodule

// File: rtl/mem_wb.sv
// Memory-access stage plus MEM/WB pipeline register.
// Non-memory instructions pass through in one cycle; loads/stores go out
// on the req/ack port while the EX/MEM register is stalled, and retire
// into the MEM/WB register on ack (or on timeout, with write-back killed).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in*                  : EX/MEM register outputs (held stable while stall)
//   stall                : hold EX/MEM register (combinational)
//   memReq/memWe/memAddr/memWData, memAck/memRData : data-memory port
//   out*                 : MEM/WB register contents for the WB stage
//   busErr               : sticky access-timeout flag
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inOp1Val,
    input  logic [DATA_W-1:0] inOp2Val,
    input  logic [DATA_W-1:0] inALUResult,
    input  logic [DATA_W-1:0] inR15Result,
    input  logic [REG_W-1:0]  inRegOp1,
    input  logic              inWB,
    input  logic              inR15Write,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic              outValid,
    output logic              outWB,
    output logic [REG_W-1:0]  outWBReg,
    output logic [DATA_W-1:0] outWBData,
    output logic              outR15Write,
    output logic [DATA_W-1:0] outR15Data,
    output logic              busErr
);
    state_t state;
    logic   ack_hit;
    logic   timeout;
    logic   mem_op;
    logic   is_load;
    logic   unused_op2;

    assign unused_op2 = ^inOp2Val;
    assign mem_op     = inValid && (inMemRead || inMemWrite);
    // Read+write together behaves as a store.
    assign is_load    = inMemRead && !inMemWrite;

    mem_port_ctrl #(.MAX_WAIT(MAX_WAIT)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (mem_op),
        .addr      (inALUResult),
        .wdata     (inOp1Val),
        .we        (inMemWrite),
        .mem_ack   (memAck),
        .state     (state),
        .req       (memReq),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWData),
        .ack_hit   (ack_hit),
        .timeout   (timeout)
    );

    assign stall = !rst && ((state == IDLE) ? mem_op : !(ack_hit || timeout));

    logic              valid_next, wb_next, r15w_next;
    logic [REG_W-1:0]  reg_next;
    logic [DATA_W-1:0] data_next, r15d_next;
    logic              valid_reg, wb_reg, r15w_reg, bus_err_reg;
    logic [REG_W-1:0]  reg_reg;
    logic [DATA_W-1:0] data_reg, r15d_reg;

    // Default is a bubble: used while an access is being started or waited on.
    always_comb begin
        valid_next = 1'b0;
        wb_next    = 1'b0;
        r15w_next  = 1'b0;
        reg_next   = '0;
        data_next  = '0;
        r15d_next  = '0;
        if (state == IDLE && !mem_op) begin
            valid_next = inValid;
            wb_next    = inWB && inValid;
            r15w_next  = inR15Write && inValid;
            reg_next   = inRegOp1;
            data_next  = inALUResult;
            r15d_next  = inR15Result;
        end else if (ack_hit) begin
            valid_next = 1'b1;
            wb_next    = is_load && inWB;
            r15w_next  = inR15Write;
            reg_next   = inRegOp1;
            data_next  = is_load ? memRData : inALUResult;
            r15d_next  = inR15Result;
        end else if (timeout) begin
            // Retire the instruction so the pipeline drains, but suppress
            // every architectural write.
            valid_next = 1'b1;
            reg_next   = inRegOp1;
            data_next  = inALUResult;
            r15d_next  = inR15Result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            wb_reg      <= 1'b0;
            r15w_reg    <= 1'b0;
            reg_reg     <= '0;
            data_reg    <= '0;
            r15d_reg    <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            wb_reg    <= wb_next;
            r15w_reg  <= r15w_next;
            reg_reg   <= reg_next;
            data_reg  <= data_next;
            r15d_reg  <= r15d_next;
            if (timeout) bus_err_reg <= 1'b1;
        end
    end

    assign outValid    = valid_reg;
    assign outWB       = wb_reg;
    assign outWBReg    = reg_reg;
    assign outWBData   = data_reg;
    assign outR15Write = r15w_reg;
    assign outR15Data  = r15d_reg;
    assign busErr      = bus_err_reg;
endmodule

// File: doc/mem_wb.md
# mem_wb

Memory-access stage and MEM/WB pipeline register for the 16-bit pipeline; consumes the EX/MEM register outputs. Performs loads and stores over a req/ack data-memory port, stalls the upstream EX/MEM register while an access is outstanding, and registers the write-back bundle (GPR and R15) for the WB stage.

## Interface
Parameters:
- MAX_WAIT, 15: cycles in ACCESS without memAck before the access is abandoned (1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inValid  in  1  EX/MEM slot holds an instruction
- inOp1Val  in  16  store data
- inOp2Val  in  16  unused by datapath, forwarded nowhere (kept for interface symmetry)
- inALUResult  in  16  ALU result / memory address
- inR15Result  in  16  R15 value
- inRegOp1  in  4  destination GPR
- inWB  in  1  GPR write-back enable
- inR15Write  in  1  R15 write enable
- inMemRead, inMemWrite  in  1 each  load / store
- stall  out  1  hold EX/MEM register (combinational)
- memReq  out  1  access request (registered)
- memWe  out  1  1 = store
- memAddr, memWData  out  16 each
- memAck  in  1  access complete this cycle
- memRData  in  16  load data, valid with memAck
- outValid  out  1  MEM/WB slot valid
- outWB  out  1  GPR write enable
- outWBReg  out  4  destination GPR
- outWBData  out  16  write-back data
- outR15Write  out  1; outR15Data  out  16
- busErr  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS.
- mem op = inValid && (inMemRead || inMemWrite); both set → store, load data discarded, outWB forced 0.
- IDLE, no mem op: at edge, out* ← inputs (outValid=inValid, outWB=inWB&&inValid, outWBData=inALUResult, outR15Write=inR15Write&&inValid); stall=0.
- IDLE, mem op: stall=1; at edge latch memAddr=inALUResult, memWData=inOp1Val, memWe=inMemWrite, memReq←1, wait counter←0, → ACCESS; outValid←0 (bubble).
- ACCESS: memReq, memAddr, memWData, memWe held constant. stall = !memAck && !timeout.
  - memAck: at edge memReq←0, → IDLE, out* loaded from the held EX/MEM inputs; outWBData = memRData for load, inALUResult for store; outWB = inWB for load, 0 for store.
  - no ack: counter++; when counter == MAX_WAIT-1 without ack → timeout: memReq←0, busErr←1, instruction retires with outValid=1, outWB=0, outR15Write=0, → IDLE.
  - memAck and timeout same cycle: ack wins, busErr unchanged.
- busErr clears only on rst.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Non-memory instruction: 1-cycle latency, full throughput.
- Memory access: accept edge → memReq high next cycle; memAck at cycle k after memReq rises → outputs valid k+1 cycles later; minimum 2 cycles/access (ack in first memReq cycle).
- memAck ignored while memReq=0.
- Upstream must keep in* stable while stall=1.
- rst mid-access: memReq low after that edge, in-flight instruction dropped, no write-back.

## Structure
- Shared package: DATA_W=16, REG_W=4, state enum {IDLE, ACCESS}.
- One sub-module natural: mem_port_ctrl (FSM, wait counter, memReq/memWe/memAddr/memWData, timeout); mem_wb holds the MEM/WB output register and mux.

## Test plan
- rst high 2 cycles with random inputs → every output 0, stall 0.
- Non-mem: inValid=1, inWB=1, inRegOp1=3, inALUResult=0x1234 → next edge outValid=1, outWB=1, outWBReg=3, outWBData=0x1234, stall never high.
- Load: inMemRead=1, inALUResult=0x0040, ack 3 cycles after memReq with memRData=0xBEEF → memAddr=0x0040, memWe=0, stall high until ack cycle, then outWBData=0xBEEF, outWB=1.
- Store: inMemWrite=1, inOp1Val=0x00AA, inALUResult=0x0010, ack in first memReq cycle → memWe=1, memWData=0x00AA, outWB=0, 2-cycle occupancy.
- Timeout: MAX_WAIT=4, load, no ack → memReq drops after 4 cycles, busErr=1 sticky, outValid=1, outWB=0; next non-mem instruction completes normally.
- rst asserted during ACCESS → memReq=0 next cycle, outValid=0, later memAck ignored.
